// File: rtl/led_pkg.sv
// Shared types for the LED pattern generator: channel mode encoding and
// the channel-index width helper.
package led_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    OFF   = 2'd0,
    ON    = 2'd1,
    BLINK = 2'd2,
    PWM   = 2'd3
  } led_mode_e;

  // Channel index width; a single-channel build still gets a 1-bit index.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_channel.sv
// One LED channel: config registers, phase counter, blink state, output flop.
// PWM duty register and comparator exist only when LED_PWM_EN is defined.
module led_channel
  import led_pkg::*;
#(
  parameter int PER_W = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             sync,
  input  logic             wr,
  input  logic [MODE_W-1:0] mode,
  input  logic [PER_W-1:0] period,
`ifdef LED_PWM_EN
  input  logic [PER_W-1:0] duty,
`endif
  output logic             led
);

  led_mode_e        mode_q;
  logic [PER_W-1:0] period_q;
  logic [PER_W-1:0] phase_q;
  logic             blink_q;
  logic [PER_W-1:0] last_phase;
  logic             running;
  logic             led_next;

`ifdef LED_PWM_EN
  logic [PER_W-1:0] duty_q;
  assign running = (mode_q == BLINK) || (mode_q == PWM);
`else
  assign running = (mode_q == BLINK);
`endif

  // A zero period behaves like period 1: the phase never leaves 0.
  assign last_phase = (period_q == '0) ? '0 : period_q - PER_W'(1);

  always_comb begin
    // NOTE: default assigned first so every path drives led_next; no latch.
    led_next = 1'b0;
    case (mode_q)
      ON:      led_next = 1'b1;
      BLINK:   led_next = blink_q;
`ifdef LED_PWM_EN
      PWM:     led_next = (period_q != '0) && (phase_q < duty_q);
`else
      PWM:     led_next = 1'b0;
`endif
      default: led_next = 1'b0;
    endcase
  end

  // NOTE: non-blocking assignments for all state so flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q   <= OFF;
      period_q <= '0;
      phase_q  <= '0;
      blink_q  <= 1'b0;
      led      <= 1'b0;
`ifdef LED_PWM_EN
      duty_q   <= '0;
`endif
    end else begin
      led <= led_next;
      if (wr) begin
        mode_q   <= led_mode_e'(mode);
        period_q <= period;
        phase_q  <= '0;
        blink_q  <= 1'b0;
`ifdef LED_PWM_EN
        duty_q   <= duty;
`endif
      end else if (sync || !running) begin
        phase_q <= '0;
        blink_q <= 1'b0;
      end else if (tick) begin
        if (phase_q == last_phase) begin
          phase_q <= '0;
          if (mode_q == BLINK) blink_q <= ~blink_q;
        end else begin
          phase_q <= phase_q + PER_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: shared tick prescaler, config handshake
// and NUM_CH led_channel instances. Define LED_PWM_EN to build PWM mode.
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int PRESCALE = 24_000,
  parameter int PER_W    = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [ch_w(NUM_CH)-1:0]  cfg_ch,
  input  logic [MODE_W-1:0]        cfg_mode,
  input  logic [PER_W-1:0]         cfg_period,
  input  logic [PER_W-1:0]         cfg_duty,
  input  logic                     sync,
  output logic [NUM_CH-1:0]        led
);

  localparam int CH_W = ch_w(NUM_CH);
  localparam int PS_W = $clog2(PRESCALE);

  logic [PS_W-1:0]   ps_cnt;
  logic              tick;
  logic              busy_q;
  logic              accept;
  logic [NUM_CH-1:0] ch_wr;

  assign tick      = (ps_cnt == PS_W'(PRESCALE - 1));
  assign cfg_ready = ~reset & ~busy_q;
  assign accept    = cfg_valid & cfg_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      ps_cnt <= '0;
      busy_q <= 1'b0;
    end else begin
      busy_q <= accept;
      if (sync || tick) ps_cnt <= '0;
      else              ps_cnt <= ps_cnt + PS_W'(1);
    end
  end

`ifndef LED_PWM_EN
  logic unused_duty;
  assign unused_duty = ^cfg_duty;
`endif

  // Indices >= NUM_CH match no channel, so such writes only complete the handshake.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign ch_wr[gi] = accept && (cfg_ch == CH_W'(gi));

    led_channel #(.PER_W(PER_W)) u_ch (
      .clk    (clk),
      .reset  (reset),
      .tick   (tick),
      .sync   (sync),
      .wr     (ch_wr[gi]),
      .mode   (cfg_mode),
      .period (cfg_period),
`ifdef LED_PWM_EN
      .duty   (cfg_duty),
`endif
      .led    (led[gi])
    );
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench for led_pattern_gen: tick-count reference model checked
// every cycle, directed scenarios with hand-derived timing, then random traffic.
module tb_led_pattern_gen;
  import led_pkg::*;

  localparam int NUM_CH   = 4;
  localparam int PRESCALE = 4;
  localparam int PER_W    = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cfg_valid = 1'b0;
  logic       sync = 1'b0;
  logic [1:0] cfg_ch = '0;
  logic [1:0] cfg_mode = '0;
  logic [7:0] cfg_period = '0;
  logic [7:0] cfg_duty = '0;
  logic       cfg_ready;
  logic [3:0] led;
  logic       ready3;
  logic [2:0] led3;

  always #5 clk = ~clk;

  led_pattern_gen #(.NUM_CH(NUM_CH), .PRESCALE(PRESCALE), .PER_W(PER_W)) dut (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_period(cfg_period),
    .cfg_duty(cfg_duty), .sync(sync), .led(led)
  );

  // Three-channel variant so an out-of-range index is representable on a 2-bit bus.
  led_pattern_gen #(.NUM_CH(3), .PRESCALE(PRESCALE), .PER_W(PER_W)) dut3 (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(ready3),
    .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_period(cfg_period),
    .cfg_duty(cfg_duty), .sync(sync), .led(led3)
  );

  int cmp_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  int acc_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: each channel remembers how many ticks elapsed since its
  // last clear; outputs follow from that count with plain arithmetic.
  int   m_mode [NUM_CH];
  int   m_per  [NUM_CH];
  int   m_duty [NUM_CH];
  int   m_ticks[NUM_CH];
  int   m_since_clear;
  bit   m_busy;
  logic [3:0] m_led;
  logic [3:0] m_next;
  bit   m_tick;
  bit   m_acc;

  function automatic logic model_out(input int ch);
    int p;
    p = (m_per[ch] == 0) ? 1 : m_per[ch];
    case (m_mode[ch])
      1: return 1'b1;
      2: return ((m_ticks[ch] / p) % 2) == 1;
`ifdef LED_PWM_EN
      3: return (m_per[ch] != 0) && ((m_ticks[ch] % m_per[ch]) < m_duty[ch]);
`endif
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_mode[i] = 0; m_per[i] = 0; m_duty[i] = 0; m_ticks[i] = 0;
      end
      m_since_clear = 0;
      m_busy = 1'b0;
      m_led = '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) m_next[i] = model_out(i);
      m_tick = (m_since_clear % PRESCALE) == PRESCALE - 1;
      m_acc  = cfg_valid && !m_busy;
      if (sync) m_since_clear = 0;
      else      m_since_clear++;
      for (int i = 0; i < NUM_CH; i++) begin
        if (m_acc && int'(cfg_ch) == i) begin
          m_mode[i] = int'(cfg_mode); m_per[i] = int'(cfg_period);
          m_duty[i] = int'(cfg_duty); m_ticks[i] = 0;
        end else if (sync) begin
          m_ticks[i] = 0;
        end else if (m_tick) begin
          m_ticks[i]++;
        end
      end
      m_busy = m_acc;
      m_led  = m_next;
    end
    #1;
    check("model_led", led, m_led);
    check("model_cfg_ready", cfg_ready, !reset && !m_busy);
  end

  task automatic do_write(input int ch, input int mode, input int per, input int duty,
                          input bit with_sync);
    int waited = 0;
    while (cfg_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("ready_before_write", cfg_ready, 1);
    cfg_valid = 1'b1; cfg_ch = 2'(ch); cfg_mode = 2'(mode);
    cfg_period = 8'(per); cfg_duty = 8'(duty); sync = with_sync;
    @(negedge clk);
    acc_cyc = cyc;
    check("ready_low_after_accept", cfg_ready, 0);
    cfg_valid = 1'b0; sync = 1'b0;
    @(negedge clk);
    check("ready_high_again", cfg_ready, 1);
  endtask

  // Records the first four level changes of one led bit over a window.
  int   ch_n;
  int   ch_t[4];
  logic ch_v[4];

  task automatic observe(input int ch, input int ncyc);
    logic prev;
    ch_n = 0;
    prev = led[ch];
    repeat (ncyc) begin
      @(negedge clk);
      if (led[ch] !== prev) begin
        if (ch_n < 4) begin
          ch_t[ch_n] = cyc;
          ch_v[ch_n] = led[ch];
        end
        ch_n++;
        prev = led[ch];
      end
    end
  endtask

  int bad;
  int s_edge;
  int rise_edge;

  initial begin
    // Reset held three cycles.
    repeat (3) begin
      @(negedge clk);
      check("reset_led", led, 0);
      check("reset_ready", cfg_ready, 0);
    end
    reset = 1'b0;
    #1 check("ready_on_release", cfg_ready, 1);
    @(negedge clk);
    check("ready_after_first_edge", cfg_ready, 1);

    // Out-of-range index on the 3-channel variant: handshake only.
    check("oor_ready_before", ready3, 1);
    cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_mode = 2'(ON); cfg_period = 8'd0;
    @(negedge clk);
    check("oor_ready_low", ready3, 0);
    cfg_valid = 1'b0;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (led3 !== 3'b000) bad++;
    end
    check("oor_ready_back", ready3, 1);
    check("oor_led_unchanged", bad, 0);

    // BLINK ch1 period 3: 12-cycle half period, first rise 10..13 after accept.
    do_write(1, BLINK, 3, 0, 1'b0);
    observe(1, 60);
    check("blink_change_count_ge3", ch_n >= 3, 1);
    check("blink_first_is_rise", ch_v[0], 1);
    check("blink_first_rise_window",
          (ch_t[0] - acc_cyc >= 10) && (ch_t[0] - acc_cyc <= 13), 1);
    check("blink_half_period_a", ch_t[1] - ch_t[0], 12);
    check("blink_half_period_b", ch_t[2] - ch_t[1], 12);

    // PWM ch2 period 4 duty 1: high 4, low 12.
    do_write(2, PWM, 4, 1, 1'b0);
    observe(2, 48);
`ifdef LED_PWM_EN
    check("pwm_change_count_ge3", ch_n >= 3, 1);
    for (int k = 1; k < 3; k++)
      check("pwm_run_length", ch_t[k] - ch_t[k-1], ch_v[k-1] ? 4 : 12);
`else
    check("pwm_off_no_changes", ch_n, 0);
    check("pwm_off_level", led[2], 0);
`endif

    // PWM ch3 duty >= period: constant level, then period 0 forces low.
    do_write(3, PWM, 4, 5, 1'b0);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
`ifdef LED_PWM_EN
      if (led[3] !== 1'b1) bad++;
`else
      if (led[3] !== 1'b0) bad++;
`endif
    end
    check("pwm_full_duty_level", bad, 0);
    do_write(3, PWM, 0, 5, 1'b0);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (led[3] !== 1'b0) bad++;
    end
    check("pwm_zero_period_low", bad, 0);

    // Two BLINK channels out of phase, then sync realigns them.
    do_write(0, BLINK, 2, 0, 1'b0);
    repeat (5) @(negedge clk);
    do_write(1, BLINK, 2, 0, 1'b0);
    repeat (7) @(negedge clk);
    sync = 1'b1;
    @(negedge clk);
    s_edge = cyc;
    sync = 1'b0;
    @(negedge clk);
    check("sync_blink_low_next_edge", led[1:0], 2'b00);
    rise_edge = -1;
    for (int i = 0; i < 20 && rise_edge < 0; i++) begin
      @(negedge clk);
      if (led[1:0] != 2'b00) begin
        rise_edge = cyc;
        check("sync_rise_together", led[1:0], 2'b11);
      end
    end
    check("sync_rise_edge", rise_edge - s_edge, 9);

    // Write presented during reset is discarded.
    reset = 1'b1; cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_mode = 2'(ON);
    repeat (2) begin
      @(negedge clk);
      check("reset_write_ready_low", cfg_ready, 0);
    end
    reset = 1'b0; cfg_valid = 1'b0;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (led !== 4'b0000) bad++;
    end
    check("reset_write_discarded", bad, 0);

    // Random traffic against the model.
    repeat (4000) begin
      @(negedge clk);
      if (reset) begin
        if ($urandom_range(0, 2) == 0) reset = 1'b0;
      end else if ($urandom_range(0, 799) == 0) begin
        reset = 1'b1;
      end
      cfg_valid  = ($urandom_range(0, 15) == 0);
      cfg_ch     = 2'($urandom_range(0, 3));
      cfg_mode   = 2'($urandom_range(0, 3));
      cfg_period = 8'($urandom_range(0, 6));
      cfg_duty   = 8'($urandom_range(0, 7));
      sync       = ($urandom_range(0, 59) == 0);
    end
    @(negedge clk);
    cfg_valid = 1'b0; sync = 1'b0; reset = 1'b0;
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (compared %0d)", cmp_cnt);
    $fatal(1, "watchdog");
  end

endmodule
